// File: rtl/spi_master_ctrl_if.sv
// Host-side handshake bundle for spi_master_ctrl.
//   start   : transfer request (host -> controller)
//   tx_data : word to transmit, captured when start is accepted
//   rx_data : last received word, updated on done
//   busy    : transfer in progress
//   done    : one-cycle completion pulse
// Modport master is the host; modport slave is the controller.
interface spi_master_ctrl_if #(
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output tx_data,
      input  rx_data,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  tx_data,
      output rx_data,
      output busy,
      output done
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, single chip select.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : host handshake (start, tx_data, rx_data, busy, done)
//   spi_sclk  : SPI clock, idles high
//   spi_cs_n  : active-low chip select
//   spi_mosi  : serial data out, changes on falling SCLK
//   spi_miso  : serial data in, sampled on rising SCLK
// A transfer is SETUP (CLK_DIV cycles), DATA_W SCLK periods, then HOLD
// (CLK_DIV cycles); all outputs come straight from flops.
module spi_master_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   spi_master_ctrl_if.slave bus,
   output logic             spi_sclk,
   output logic             spi_cs_n,
   output logic             spi_mosi,
   input  logic             spi_miso
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   logic [CNT_W-1:0]  half_q,    half_d;
   logic [BIT_W-1:0]  bit_q,     bit_d;
   logic [DATA_W-1:0] tx_q,      tx_d;
   logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              sclk_q,    sclk_d;
   logic              cs_n_q,    cs_n_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         half_q    <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         half_q    <= half_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      half_d    = half_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SETUP;
               half_d  = HALF_RELOAD;
               bit_d   = BIT_W'(DATA_W);
               tx_d    = bus.tx_data;
               rx_sr_d = '0;
               sclk_d  = 1'b1;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         SETUP: begin
            if (half_q == '0) begin
               // First falling edge; the MSB is already on mosi.
               state_d = SHIFT;
               half_d  = HALF_RELOAD;
               sclk_d  = 1'b0;
            end else begin
               half_d = half_q - CNT_W'(1);
            end
         end

         SHIFT: begin
            if (half_q != '0) begin
               half_d = half_q - CNT_W'(1);
            end else if (!sclk_q) begin
               // Rising edge: capture miso into the LSB.
               sclk_d  = 1'b1;
               half_d  = HALF_RELOAD;
               rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
               bit_d   = bit_q - BIT_W'(1);
            end else if (bit_q == '0) begin
               // High phase of the last bit has elapsed.
               state_d = HOLD;
               half_d  = HALF_RELOAD;
            end else begin
               // Falling edge: advance to the next bit.
               sclk_d = 1'b0;
               half_d = HALF_RELOAD;
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
         end

         HOLD: begin
            if (half_q == '0) begin
               state_d   = IDLE;
               cs_n_d    = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sr_q;
               tx_d      = '0;
            end else begin
               half_d = half_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // mosi is the transmit register MSB; it is cleared on completion so idle mosi is 0.
   assign spi_mosi    = tx_q[DATA_W-1];
   assign spi_sclk    = sclk_q;
   assign spi_cs_n    = cs_n_q;
   assign bus.rx_data = rx_data_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

   localparam int unsigned DW_A  = 16;
   localparam int unsigned DIV_A = 4;
   localparam int unsigned DW_B  = 8;
   localparam int unsigned DIV_B = 1;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: default geometry
   spi_master_ctrl_if #(.DATA_W(DW_A)) bus_a ();
   logic sclk_a, cs_n_a, mosi_a, miso_a;

   spi_master_ctrl #(.DATA_W(DW_A), .CLK_DIV(DIV_A)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_a),
      .spi_sclk (sclk_a),
      .spi_cs_n (cs_n_a),
      .spi_mosi (mosi_a),
      .spi_miso (miso_a)
   );

   // Instance B: fastest SCLK, short word
   spi_master_ctrl_if #(.DATA_W(DW_B)) bus_b ();
   logic sclk_b, cs_n_b, mosi_b, miso_b;

   spi_master_ctrl #(.DATA_W(DW_B), .CLK_DIV(DIV_B)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_b),
      .spi_sclk (sclk_b),
      .spi_cs_n (cs_n_b),
      .spi_mosi (mosi_b),
      .spi_miso (miso_b)
   );

   // Mode-3 target model: presents the next word bit on each falling SCLK.
   // While SCLK is high the line carries noise, so only a rising-edge sample
   // sees the intended bit.
   bit          loop_mode  = 1'b1;
   logic [15:0] slave_word = '0;
   logic        slave_bit  = 1'b0;
   logic        noise      = 1'b0;
   int          slave_idx  = -1;

   always @(negedge clk) noise <= 1'($urandom_range(0, 1));
   always @(negedge cs_n_a) slave_idx = DW_A - 1;
   always @(negedge sclk_a) begin
      if (cs_n_a === 1'b0 && slave_idx >= 0) begin
         slave_bit = slave_word[slave_idx];
         slave_idx--;
      end
   end
   assign miso_a = loop_mode ? mosi_a : (sclk_a ? noise : slave_bit);

   // Bus observer for instance A
   int          cs_run = 0, last_cs_len = 0, gap_run = 0, last_gap = 0;
   int          rises = 0, mosi_viol = 0, done_cnt = 0, n_xfer = 0;
   logic [15:0] mosi_word = '0;
   bit          prev_low = 1'b0, prev_sclk = 1'b1, prev_mosi = 1'b0;

   always @(negedge clk) begin
      if (cs_n_a === 1'b0) begin
         if (!prev_low) begin
            cs_run    = 0;
            rises     = 0;
            mosi_word = '0;
            last_gap  = gap_run;
            n_xfer++;
         end
         cs_run++;
         if (prev_low && !prev_sclk && sclk_a === 1'b1) begin
            rises++;
            mosi_word = {mosi_word[14:0], mosi_a};
         end
         if (prev_low && (mosi_a !== prev_mosi) && !(prev_sclk && sclk_a === 1'b0))
            mosi_viol++;
      end else begin
         if (prev_low) begin
            last_cs_len = cs_run;
            gap_run     = 0;
         end
         gap_run++;
      end
      if (bus_a.done === 1'b1) done_cnt++;
      prev_low  = (cs_n_a === 1'b0);
      prev_sclk = (sclk_a === 1'b1);
      prev_mosi = (mosi_a === 1'b1);
   end

   // Issue one transfer on A and wait (bounded) for its done pulse.
   task automatic run_xfer_a(input logic [15:0] tx, output logic [15:0] rx_at_done,
                             output bit timed_out);
      @(negedge clk);
      bus_a.start   = 1'b1;
      bus_a.tx_data = tx;
      @(negedge clk);
      bus_a.start   = 1'b0;
      bus_a.tx_data = 16'($urandom);
      timed_out  = 1'b1;
      rx_at_done = '0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) begin
            timed_out  = 1'b0;
            rx_at_done = bus_a.rx_data;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus_a.start   = 1'b1;
      bus_a.tx_data = 16'hFFFF;
      bus_b.start   = 1'b1;
      bus_b.tx_data = 8'hFF;
      miso_b        = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk_a); end
      checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1 (rst over start)", cs_n_a); end
      checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
      checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
      checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
      checks++; if (bus_a.rx_data !== 16'h0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0000", bus_a.rx_data); end
      checks++; if (cs_n_b !== 1'b1 || bus_b.rx_data !== 8'h0) begin failures++; $display("FAIL reset_b got cs_n=%b rx=%h exp cs_n=1 rx=00", cs_n_b, bus_b.rx_data); end
      rst         = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loopback();
      logic [15:0] rx;
      bit          to;
      int          d0;
      loop_mode = 1'b1;
      d0 = done_cnt;
      run_xfer_a(16'hA5C3, rx, to);
      checks++; if (to) begin failures++; $display("FAIL loop_timeout got=no_done exp=done"); end
      checks++; if (rx !== 16'hA5C3) begin failures++; $display("FAIL loop_rx got=%h exp=a5c3", rx); end
      checks++; if (bus_a.rx_data !== 16'hA5C3) begin failures++; $display("FAIL loop_rx_hold got=%h exp=a5c3", bus_a.rx_data); end
      checks++; if (last_cs_len != int'(DIV_A * (2 * DW_A + 2))) begin failures++; $display("FAIL loop_cs_len got=%0d exp=%0d", last_cs_len, DIV_A * (2 * DW_A + 2)); end
      checks++; if (rises != int'(DW_A)) begin failures++; $display("FAIL loop_sclk_periods got=%0d exp=%0d", rises, DW_A); end
      checks++; if (mosi_word !== 16'hA5C3) begin failures++; $display("FAIL loop_mosi_word got=%h exp=a5c3", mosi_word); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL loop_done_pulses got=%0d exp=1", done_cnt - d0); end
      checks++; if (bus_a.busy !== 1'b0 || cs_n_a !== 1'b1 || mosi_a !== 1'b0) begin failures++; $display("FAIL loop_post_idle got busy=%b cs_n=%b mosi=%b exp 0/1/0", bus_a.busy, cs_n_a, mosi_a); end
   endtask

   task automatic test_slave_model();
      logic [15:0] rx, tx;
      bit          to;
      loop_mode = 1'b0;
      for (int n = 0; n < 6; n++) begin
         slave_word = (n == 0) ? 16'h0C80 : 16'($urandom);
         tx         = 16'($urandom);
         run_xfer_a(tx, rx, to);
         checks++; if (to || rx !== slave_word) begin failures++; $display("FAIL slave_rx[%0d] got=%h exp=%h timeout=%0b", n, rx, slave_word, to); end
         checks++; if (mosi_word !== tx) begin failures++; $display("FAIL slave_mosi_word[%0d] got=%h exp=%h", n, mosi_word, tx); end
         checks++; if (last_cs_len != int'(DIV_A * (2 * DW_A + 2))) begin failures++; $display("FAIL slave_cs_len[%0d] got=%0d exp=%0d", n, last_cs_len, DIV_A * (2 * DW_A + 2)); end
      end
      checks++; if (mosi_viol != 0) begin failures++; $display("FAIL mosi_edge got=%0d changes_off_falling exp=0", mosi_viol); end
      loop_mode = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [15:0] t1, t2;
      int          d0, x0, seen;
      bit          to;
      t1 = 16'($urandom);
      t2 = 16'($urandom);
      d0 = done_cnt;
      x0 = n_xfer;
      seen = 0;
      to = 1'b1;
      @(negedge clk);
      bus_a.start   = 1'b1;
      bus_a.tx_data = t1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) begin
            seen++;
            if (seen == 1) begin
               checks++; if (bus_a.rx_data !== t1) begin failures++; $display("FAIL b2b_rx1 got=%h exp=%h", bus_a.rx_data, t1); end
               // start is still high in this done cycle, so this word is accepted.
               bus_a.tx_data = t2;
            end else begin
               checks++; if (bus_a.rx_data !== t2) begin failures++; $display("FAIL b2b_rx2 got=%h exp=%h", bus_a.rx_data, t2); end
               to = 1'b0;
               break;
            end
         end else if (seen == 1) begin
            bus_a.start   = 1'b0;
            bus_a.tx_data = 16'($urandom);
         end else begin
            bus_a.tx_data = 16'($urandom);
         end
      end
      bus_a.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (to) begin failures++; $display("FAIL b2b_timeout got=%0d dones exp=2", seen); end
      checks++; if (n_xfer - x0 != 2) begin failures++; $display("FAIL b2b_transfers got=%0d exp=2", n_xfer - x0); end
      checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt - d0); end
      checks++; if (last_gap != 1) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp=1", last_gap); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] tx, rx;
      bit          to;
      int          d0;
      tx = 16'($urandom) | 16'h0001;
      d0 = done_cnt;
      @(negedge clk);
      bus_a.start   = 1'b1;
      bus_a.tx_data = tx;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cs_n_a !== 1'b1 || sclk_a !== 1'b1) begin failures++; $display("FAIL abort_pins got cs_n=%b sclk=%b exp 1/1", cs_n_a, sclk_a); end
      checks++; if (bus_a.busy !== 1'b0 || bus_a.rx_data !== 16'h0) begin failures++; $display("FAIL abort_regs got busy=%b rx=%h exp 0/0000", bus_a.busy, bus_a.rx_data); end
      // Release reset and request in the same cycle; the request is taken at the next edge.
      rst           = 1'b0;
      bus_a.start   = 1'b1;
      bus_a.tx_data = tx;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++; if (cs_n_a !== 1'b0 || bus_a.busy !== 1'b1) begin failures++; $display("FAIL post_reset_start got cs_n=%b busy=%b exp 0/1", cs_n_a, bus_a.busy); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_done got=%0d pulses exp=0", done_cnt - d0); end
      to = 1'b1;
      rx = '0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) begin to = 1'b0; rx = bus_a.rx_data; break; end
      end
      checks++; if (to || rx !== tx) begin failures++; $display("FAIL post_reset_rx got=%h exp=%h timeout=%0b", rx, tx, to); end
      @(negedge clk);
   endtask

   task automatic test_idle();
      int bad = 0;
      bus_a.start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (sclk_a !== 1'b1 || cs_n_a !== 1'b1 || mosi_a !== 1'b0 || bus_a.busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL idle_1000 got=%0d bad_cycles exp=0", bad); end
   endtask

   task automatic test_min_div();
      for (int n = 0; n < 2; n++) begin
         logic [7:0] exp_rx;
         int         low_cnt, toggles;
         bit         to, psclk;
         miso_b  = (n == 0);
         exp_rx  = (n == 0) ? 8'hFF : 8'h00;
         low_cnt = 0;
         toggles = 0;
         psclk   = 1'b1;
         to      = 1'b1;
         @(negedge clk);
         bus_b.start   = 1'b1;
         bus_b.tx_data = 8'hFF;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (cs_n_b === 1'b0) begin
               low_cnt++;
               if (sclk_b !== psclk) toggles++;
            end
            psclk = (sclk_b === 1'b1);
            if (bus_b.done === 1'b1) begin to = 1'b0; break; end
         end
         checks++; if (to || bus_b.rx_data !== exp_rx) begin failures++; $display("FAIL div1_rx[%0d] got=%h exp=%h timeout=%0b", n, bus_b.rx_data, exp_rx, to); end
         checks++; if (low_cnt != int'(DIV_B * (2 * DW_B + 2))) begin failures++; $display("FAIL div1_cs_len[%0d] got=%0d exp=%0d", n, low_cnt, DIV_B * (2 * DW_B + 2)); end
         checks++; if (toggles != int'(2 * DW_B)) begin failures++; $display("FAIL div1_sclk_toggles[%0d] got=%0d exp=%0d", n, toggles, 2 * DW_B); end
         checks++; if (bus_b.busy !== 1'b0 || mosi_b !== 1'b0) begin failures++; $display("FAIL div1_idle[%0d] got busy=%b mosi=%b exp 0/0", n, bus_b.busy, mosi_b); end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_slave_model();
      test_back_to_back();
      test_reset_mid();
      test_idle();
      test_min_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
